regfile_read_port: RTL and testbench

- 32-entry x 64-bit register file whose focus is the consumer side of the per-register write-enable storage.
- One write port.
- Two independent read ports with registered outputs and a stall hold.
- Sits between writeback and the decode/register-read stage of the pipelined CPU.
- Register 31 is the hard-wired zero register.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_read_mux.sv | 29 ++
 rtl/regfile_read_port.sv | 78 +++++++
 tb/tb_regfile_read_port.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32 x 64-bit register file and its read ports.
package regfile_pkg;

    localparam int WIDTH    = 64;
    localparam int DEPTH    = 32;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 31;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [WIDTH-1:0]  reg_word_t;

    localparam reg_addr_t ZERO_ADDR = reg_addr_t'(ZERO_REG);

endpackage

// File: rtl/regfile_read_mux.sv
// Combinational lookup for one read port: zero-register check, optional bypass, 32:1 select.
// REGFILE_WR_BYPASS_EN adds the same-edge write-to-read forwarding path and its ports.
module regfile_read_mux
    import regfile_pkg::*;
(
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DEPTH*WIDTH-1:0] entries,
`ifdef REGFILE_WR_BYPASS_EN
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
`endif
    output logic [WIDTH-1:0]       data
);

    always_comb begin
        data = entries[addr*WIDTH +: WIDTH];
`ifdef REGFILE_WR_BYPASS_EN
        if (wr_en && (wr_addr == addr)) begin
            data = wr_data;
        end
`endif
        // Zero register wins over bypass so a same-cycle write to it still reads 0.
        if (addr == ZERO_ADDR) begin
            data = '0;
        end
    end

endmodule

// File: rtl/regfile_read_port.sv
// 32 x 64-bit register file with one write port and two registered, stallable read ports.
// Build with REGFILE_WR_BYPASS_EN to forward a same-edge write into a same-edge read.
module regfile_read_port
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_req,
    input  logic              rd_stall,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              rd_valid
);

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [DEPTH*WIDTH-1:0] entries_flat;
    logic [WIDTH-1:0]       lookup_a;
    logic [WIDTH-1:0]       lookup_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (wr_addr != ZERO_ADDR)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign entries_flat[g*WIDTH +: WIDTH] = mem[g];
    end

    regfile_read_mux u_mux_a (
        .addr    (rd_addr_a),
        .entries (entries_flat),
`ifdef REGFILE_WR_BYPASS_EN
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
`endif
        .data    (lookup_a)
    );

    regfile_read_mux u_mux_b (
        .addr    (rd_addr_b),
        .entries (entries_flat),
`ifdef REGFILE_WR_BYPASS_EN
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
`endif
        .data    (lookup_b)
    );

    // Stall freezes data and valid; an idle cycle drops valid but keeps the last data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
            rd_valid  <= 1'b0;
        end else if (!rd_stall) begin
            if (rd_req) begin
                rd_data_a <= lookup_a;
                rd_data_b <= lookup_b;
                rd_valid  <= 1'b1;
            end else begin
                rd_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_read_port.sv
// Self-checking bench for regfile_read_port: directed scenarios plus randomized traffic
// checked against a behavioural array model of the register file.
module tb_regfile_read_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rd_req;
    logic        rd_stall;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [63:0] rd_data_a;
    logic [63:0] rd_data_b;
    logic        rd_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] mdl [32];
    logic [63:0] exp_a;
    logic [63:0] exp_b;
    logic        exp_v;

    always #5 clk = ~clk;

    regfile_read_port dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_stall  (rd_stall),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .rd_valid  (rd_valid)
    );

    function automatic logic [63:0] ref_lookup(input logic [4:0] x);
        if (x == 5'd31) return 64'd0;
`ifdef REGFILE_WR_BYPASS_EN
        if (wr_en && wr_addr == x) return wr_data;
`endif
        return mdl[x];
    endfunction

    // Applies the current inputs to the model as one rising edge.
    function automatic void model_edge();
        logic [63:0] la, lb;
        if (reset) begin
            for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
            exp_a = 64'd0;
            exp_b = 64'd0;
            exp_v = 1'b0;
            return;
        end
        la = ref_lookup(rd_addr_a);
        lb = ref_lookup(rd_addr_b);
        if (!rd_stall) begin
            if (rd_req) begin
                exp_a = la;
                exp_b = lb;
                exp_v = 1'b1;
            end else begin
                exp_v = 1'b0;
            end
        end
        if (wr_en && wr_addr != 5'd31) mdl[wr_addr] = wr_data;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        reset    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = 5'd0;
        wr_data  = 64'd0;
        rd_req   = 1'b0;
        rd_stall = 1'b0;
        rd_addr_a = 5'd0;
        rd_addr_b = 5'd0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1; rd_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h5555;
        tick();
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data_a !== 64'd0 || rd_data_b !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: a=%h b=%h v=%b, want 0 0 0", rd_data_a, rd_data_b, rd_valid);
        end
        idle();
        rd_req = 1'b1; rd_addr_a = 5'd3; rd_addr_b = 5'd31;
        tick();
        n_checks++;
        if (rd_data_a !== 64'd0 || rd_data_b !== 64'd0 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_then_read: a=%h b=%h v=%b, want 0 0 1", rd_data_a, rd_data_b, rd_valid);
        end
    endtask

    task automatic test_write_read();
        idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF_0000_0001;
        tick();
        idle();
        rd_req = 1'b1; rd_addr_a = 5'd5; rd_addr_b = 5'd5;
        tick();
        n_checks++;
        if (rd_data_a !== 64'hDEAD_BEEF_0000_0001) begin
            n_fail++;
            $display("FAIL write_read_a: got %h want deadbeef00000001", rd_data_a);
        end
        n_checks++;
        if (rd_data_b !== rd_data_a || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL same_addr_ports: b=%h a=%h v=%b, want b==a v=1", rd_data_b, rd_data_a, rd_valid);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        rd_req = 1'b1; rd_addr_a = 5'd31; rd_addr_b = 5'd31;
        tick();
        n_checks++;
        if (rd_data_a !== 64'd0 || rd_data_b !== 64'd0) begin
            n_fail++;
            $display("FAIL zero_same_cycle: a=%h b=%h want 0", rd_data_a, rd_data_b);
        end
        idle();
        rd_req = 1'b1; rd_addr_a = 5'd31; rd_addr_b = 5'd5;
        tick();
        n_checks++;
        if (rd_data_a !== 64'd0 || rd_data_b !== 64'hDEAD_BEEF_0000_0001) begin
            n_fail++;
            $display("FAIL zero_after_write: a=%h b=%h want 0 deadbeef00000001", rd_data_a, rd_data_b);
        end
    endtask

    task automatic test_same_cycle();
        logic [63:0] want;
        idle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h11;
        tick();
        wr_data = 64'h22; rd_req = 1'b1; rd_addr_a = 5'd7; rd_addr_b = 5'd7;
        tick();
`ifdef REGFILE_WR_BYPASS_EN
        want = 64'h22;
`else
        want = 64'h11;
`endif
        n_checks++;
        if (rd_data_a !== want) begin
            n_fail++;
            $display("FAIL same_cycle_rw: got %h want %h", rd_data_a, want);
        end
        idle();
        rd_req = 1'b1; rd_addr_a = 5'd7;
        tick();
        n_checks++;
        if (rd_data_a !== 64'h22) begin
            n_fail++;
            $display("FAIL read_after_rw: got %h want 22", rd_data_a);
        end
    endtask

    task automatic test_stall();
        idle();
        rd_req = 1'b1; rd_addr_a = 5'd5; rd_addr_b = 5'd7;
        tick();
        n_checks++;
        if (rd_data_a !== 64'hDEAD_BEEF_0000_0001 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_pre_read: a=%h v=%b want deadbeef00000001 1", rd_data_a, rd_valid);
        end
        rd_stall = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h99;
        for (int i = 0; i < 3; i++) begin
            rd_req = i[0] ? 1'b0 : 1'b1;
            tick();
            n_checks++;
            if (rd_data_a !== 64'hDEAD_BEEF_0000_0001 || rd_data_b !== 64'h22 || rd_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: a=%h b=%h v=%b want deadbeef00000001 22 1",
                         i, rd_data_a, rd_data_b, rd_valid);
            end
        end
        idle();
        rd_req = 1'b1; rd_addr_a = 5'd5;
        tick();
        n_checks++;
        if (rd_data_a !== 64'h99 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: a=%h v=%b want 99 1", rd_data_a, rd_valid);
        end
        idle();
        tick();
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data_a !== 64'h99) begin
            n_fail++;
            $display("FAIL idle_drop_valid: a=%h v=%b want 99 0", rd_data_a, rd_valid);
        end
    endtask

    task automatic test_reset_midstream();
        idle();
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'h44;
        tick();
        idle();
        rd_req = 1'b1; rd_addr_a = 5'd2; rd_addr_b = 5'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (rd_data_a !== 64'h44 || rd_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: a=%h v=%b want 44 1", i, rd_data_a, rd_valid);
            end
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (rd_data_a !== 64'd0 || rd_data_b !== 64'd0 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midstream_reset: a=%h b=%h v=%b want 0 0 0", rd_data_a, rd_data_b, rd_valid);
        end
        reset = 1'b0; rd_req = 1'b0;
        tick();
        n_checks++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_needs_req: v=%b want 0", rd_valid);
        end
        rd_req = 1'b1;
        tick();
        n_checks++;
        if (rd_data_a !== 64'd0 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL read_after_reset: a=%h v=%b want 0 1", rd_data_a, rd_valid);
        end
    endtask

    task automatic test_random();
        idle();
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(99) < 2);
            wr_en     = ($urandom_range(99) < 60);
            wr_addr   = 5'($urandom_range(31));
            wr_data   = {$urandom, $urandom};
            rd_req    = ($urandom_range(99) < 70);
            rd_stall  = ($urandom_range(99) < 25);
            rd_addr_a = 5'($urandom_range(31));
            rd_addr_b = ($urandom_range(99) < 20) ? rd_addr_a : 5'($urandom_range(31));
            if ($urandom_range(99) < 25) rd_addr_a = wr_addr;
            tick();
            n_checks++;
            if (rd_data_a !== exp_a || rd_data_b !== exp_b || rd_valid !== exp_v) begin
                n_fail++;
                $display("FAIL random[%0d]: a=%h b=%h v=%b want %h %h %b",
                         c, rd_data_a, rd_data_b, rd_valid, exp_a, exp_b, exp_v);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_same_cycle();
        test_stall();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
